sbit_frame_sync: RTL and testbench
==================================

SBIT_FRAME_SYNC -- requirements
Module: sbit_frame_sync

Interface
REQ-001 Parameter NUM_VFATS, default 24: number of trigger units (channels).
REQ-002 Parameter LANES, default 8: s-bit lanes per channel.
REQ-003 Parameter FRAME_BITS, default 8: bits per frame per lane; power of two, 2..16.
REQ-004 Parameter LOCK_CNT, default 4: consecutive matching start-of-frame (SOF) words required to lock.
REQ-005 Parameter UNLOCK_CNT, default 2: consecutive bad SOF words that drop lock.
REQ-006 Parameter ERRCNT_W, default 8: width of each per-channel error counter.
REQ-007 clock  in  1  single clock for all logic; one frame word per lane per cycle.
REQ-008 reset_i  in  1  synchronous, active-high reset.
REQ-009 sbit_mask  in  NUM_VFATS  1 = channel masked.
REQ-010 realign_i  in  1  single-cycle pulse; forces every channel to re-lock.
REQ-011 sof_word  in  NUM_VFATS*FRAME_BITS  raw deserialized SOF word per channel, arbitrary rotation.
REQ-012 data_word  in  NUM_VFATS*LANES*FRAME_BITS  raw deserialized words; channel c, lane l at offset (c*LANES+l)*FRAME_BITS.
REQ-013 sbits  out  NUM_VFATS*LANES*FRAME_BITS  aligned s-bits, same packing as data_word.
REQ-014 locked  out  NUM_VFATS  channel lock status.
REQ-015 phase  out  NUM_VFATS*clog2(FRAME_BITS)  current/candidate phase k per channel.
REQ-016 err_cnt  out  NUM_VFATS*ERRCNT_W  saturating per-channel bad-SOF counters while locked.
REQ-017 sump  out  1  OR-reduction of otherwise unused internal signals.

Function
REQ-018 An SOF word is valid iff exactly one bit is set; its bit index is k.
REQ-019 Each lane keeps one previous word p; the aligned word is bits [k +: FRAME_BITS] of {current, p} (p in LSBs).
REQ-020 sbits is registered: cycle t+1 shows the alignment of data(t) and data(t-1) using the phase of cycle t; latency 1 clock.
REQ-021 sbits for a channel are zero when that channel is not locked or masked.
REQ-022 Each channel has an FSM with states UNLOCKED, CHECK and LOCKED.
REQ-023 UNLOCKED with a valid SOF: phase<=k, match_cnt<=1, go to CHECK; if LOCK_CNT==1, go to LOCKED instead.
REQ-024 CHECK with a valid SOF equal to phase: match_cnt++; on reaching LOCK_CNT, go to LOCKED.
REQ-025 CHECK with a valid SOF that differs from phase: phase<=k, match_cnt<=1, stay in CHECK.
REQ-026 CHECK with an invalid SOF: go to UNLOCKED, match_cnt<=0.
REQ-027 LOCKED: phase is frozen; a valid SOF equal to phase sets miss_cnt<=0.
REQ-028 LOCKED with any other SOF: miss_cnt++ and err_cnt increments, saturating at all-ones.
REQ-029 LOCKED: when miss_cnt reaches UNLOCK_CNT, go to UNLOCKED and clear miss_cnt.
REQ-030 locked=1 only in LOCKED; it is a registered output, asserted the cycle after the transition.
REQ-031 A masked channel is held in UNLOCKED and its err_cnt does not change.
REQ-032 realign_i sends all channels to UNLOCKED on the next cycle, overrides any simultaneous SOF event, and does not clear err_cnt.
REQ-033 Channels operate independently; no channel's state affects another channel.

Reset
REQ-034 While reset_i is high: all FSMs go to UNLOCKED; phase, match_cnt, miss_cnt, err_cnt, the p registers, sbits and locked are all cleared.
REQ-035 Asserting reset_i mid-lock drops locked on the next edge; operation restarts from UNLOCKED after release.

Structure
REQ-036 The FSM state encoding and a clog2 helper function live in the shared trigger package.
REQ-037 Sub-module sof_lock_fsm holds one channel's FSM, counters and phase.
REQ-038 The top level generates NUM_VFATS sof_lock_fsm instances plus the per-lane rotation datapath.

Verification
REQ-039 Apply SOF=8'h08 constantly on channel 0 with LOCK_CNT=4 -> locked[0] rises 5 cycles after the first SOF, and phase[0]=3.
REQ-040 Locked at k=3 with a lane stream of p=8'hA5 then current=8'h3C -> aligned word = bits[3+:8] of 16'h3CA5 = 8'h94.
REQ-041 Locked, then one SOF=8'h00 followed by a good SOF -> lock is held and err_cnt=1; two consecutive 8'h00 -> locked falls and err_cnt=2.
REQ-042 SOF sequence 08,08,10,10,10,10 -> CHECK restarts at k=4 on the third word; locked rises after the sixth word with phase=4.
REQ-043 realign_i pulses in the same cycle as a good SOF while all 24 channels are locked -> all locked bits are 0 the next cycle, err_cnt is unchanged, and the channels re-lock after LOCK_CNT good words.
REQ-044 With sbit_mask[5]=1 and bad SOF words, and err_cnt forced toward 8'hFF on channel 6 -> channel 5 stays unlocked with err_cnt=0 and sbits=0, and channel 6 saturates at 8'hFF.

Source files
------------

// File: rtl/sbit_frame_sync_pkg.sv
// Shared trigger-path definitions: per-channel lock FSM encoding and a
// constant-evaluable ceil(log2) helper used to size ports and counters.
package sbit_frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Never returns less than 1 so that single-value fields still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sbit_frame_sync_fsm.sv
// One channel's start-of-frame lock tracker: detects the one-hot SOF phase,
// qualifies it over LOCK_CNT frames and counts bad SOF words while locked.
module sof_lock_fsm
    import sbit_frame_sync_pkg::*;
#(
    parameter int FRAME_BITS = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERRCNT_W   = 8,
    localparam int PHASE_W   = clog2(FRAME_BITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mask,
    input  logic                  realign,
    input  logic [FRAME_BITS-1:0] sof_word,
    output logic [PHASE_W-1:0]    phase,
    output logic                  lock_next,
    output logic                  locked,
    output logic [ERRCNT_W-1:0]   err_cnt
);
    localparam int MATCH_W = clog2(LOCK_CNT + 1);
    localparam int MISS_W  = clog2(UNLOCK_CNT + 1);

    lock_state_t        state;
    lock_state_t        state_nxt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic [PHASE_W-1:0] sof_k;
    logic               sof_valid;
    logic               sof_good;
    logic               hold;
    logic               match_done;
    logic               miss_done;
    logic               err_inc;

    always_comb begin
        sof_k = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (sof_word[i]) sof_k = PHASE_W'(i);
        end
    end

    assign sof_valid  = $onehot(sof_word);
    assign sof_good   = sof_valid && (sof_k == phase);
    assign hold       = realign || mask;
    assign match_done = (int'(match_cnt) + 1) >= LOCK_CNT;
    assign miss_done  = (int'(miss_cnt) + 1) >= UNLOCK_CNT;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_UNLOCKED;
        else       state <= state_nxt;
    end

    // Realign and mask win over whatever the SOF word says this cycle.
    always_comb begin
        state_nxt = state;
        if (hold) begin
            state_nxt = ST_UNLOCKED;
        end else begin
            case (state)
                ST_UNLOCKED: if (sof_valid) state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
                ST_CHECK: begin
                    if (!sof_valid)                 state_nxt = ST_UNLOCKED;
                    else if (sof_good && match_done) state_nxt = ST_LOCKED;
                end
                ST_LOCKED:   if (!sof_good && miss_done) state_nxt = ST_UNLOCKED;
                default:     state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    // lock_next drops in the same cycle the FSM leaves LOCKED, so realign
    // and unlock are visible one edge later rather than two.
    always_comb begin
        lock_next = (state == ST_LOCKED) && (state_nxt == ST_LOCKED);
        err_inc   = (state == ST_LOCKED) && !hold && !sof_good;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase     <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
            locked    <= 1'b0;
        end else begin
            locked <= lock_next;
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            if (hold) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
            end else begin
                case (state)
                    ST_UNLOCKED: begin
                        miss_cnt <= '0;
                        if (sof_valid) begin
                            phase     <= sof_k;
                            match_cnt <= MATCH_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (!sof_valid) begin
                            match_cnt <= '0;
                        end else if (sof_good) begin
                            match_cnt <= match_cnt + 1'b1;
                        end else begin
                            phase     <= sof_k;
                            match_cnt <= MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (sof_good) begin
                            miss_cnt <= '0;
                        end else if (miss_done) begin
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                    default: begin
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sbit_frame_sync.sv
// S-bit frame aligner: per-channel SOF lock trackers plus a per-lane barrel
// rotation of {current, previous} words selected by the channel phase.
module sbit_frame_sync
    import sbit_frame_sync_pkg::*;
#(
    parameter int NUM_VFATS  = 24,
    parameter int LANES      = 8,
    parameter int FRAME_BITS = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERRCNT_W   = 8,
    localparam int PHASE_W   = clog2(FRAME_BITS)
) (
    input  logic                                clock,
    input  logic                                reset_i,
    input  logic [NUM_VFATS-1:0]                sbit_mask,
    input  logic                                realign_i,
    input  logic [NUM_VFATS*FRAME_BITS-1:0]       sof_word,
    input  logic [NUM_VFATS*LANES*FRAME_BITS-1:0] data_word,
    output logic [NUM_VFATS*LANES*FRAME_BITS-1:0] sbits,
    output logic [NUM_VFATS-1:0]                locked,
    output logic [NUM_VFATS*PHASE_W-1:0]        phase,
    output logic [NUM_VFATS*ERRCNT_W-1:0]       err_cnt,
    output logic                                sump
);
    logic [NUM_VFATS-1:0]       lock_next;
    logic [NUM_VFATS*LANES-1:0] spill;

    for (genvar c = 0; c < NUM_VFATS; c++) begin : g_chan
        logic [PHASE_W-1:0] chan_phase;

        sof_lock_fsm #(
            .FRAME_BITS (FRAME_BITS),
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_CNT (UNLOCK_CNT),
            .ERRCNT_W   (ERRCNT_W)
        ) u_fsm (
            .clock     (clock),
            .reset     (reset_i),
            .mask      (sbit_mask[c]),
            .realign   (realign_i),
            .sof_word  (sof_word[c*FRAME_BITS +: FRAME_BITS]),
            .phase     (chan_phase),
            .lock_next (lock_next[c]),
            .locked    (locked[c]),
            .err_cnt   (err_cnt[c*ERRCNT_W +: ERRCNT_W])
        );

        assign phase[c*PHASE_W +: PHASE_W] = chan_phase;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int OFS = (c*LANES + l) * FRAME_BITS;
            logic [FRAME_BITS-1:0]   prev_p0;
            logic [FRAME_BITS-1:0]   sbits_p1;
            logic [2*FRAME_BITS-1:0] shifted_p0;

            assign shifted_p0 = {data_word[OFS +: FRAME_BITS], prev_p0} >> chan_phase;
            assign spill[c*LANES + l] = |shifted_p0[2*FRAME_BITS-1:FRAME_BITS];

            // Stage p0 -> p1: aligned word registered, gated by lock status.
            always_ff @(posedge clock) begin
                if (reset_i) begin
                    prev_p0  <= '0;
                    sbits_p1 <= '0;
                end else begin
                    prev_p0  <= data_word[OFS +: FRAME_BITS];
                    sbits_p1 <= lock_next[c] ? shifted_p0[FRAME_BITS-1:0] : '0;
                end
            end

            assign sbits[OFS +: FRAME_BITS] = sbits_p1;
        end
    end

    assign sump = |spill;

endmodule

// File: tb/tb_sbit_frame_sync.sv
// Directed bench for sbit_frame_sync: lock latency, alignment, miss handling,
// realign, masking, error saturation and mid-lock reset.
module tb_sbit_frame_sync;
    localparam int NV = 24;
    localparam int LN = 8;
    localparam int FB = 8;
    localparam int PW = 3;
    localparam int EW = 8;

    typedef struct {
        string      tag;
        int         ch;
        logic [7:0] exp;
    } sb_t;

    logic                clock = 1'b0;
    logic                reset_i;
    logic [NV-1:0]       sbit_mask;
    logic                realign_i;
    logic [NV*FB-1:0]    sof_word;
    logic [NV*LN*FB-1:0] data_word;
    logic [NV*LN*FB-1:0] sbits;
    logic [NV-1:0]       locked;
    logic [NV*PW-1:0]    phase;
    logic [NV*EW-1:0]    err_cnt;
    logic                sump;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    sbit_frame_sync dut (
        .clock     (clock),
        .reset_i   (reset_i),
        .sbit_mask (sbit_mask),
        .realign_i (realign_i),
        .sof_word  (sof_word),
        .data_word (data_word),
        .sbits     (sbits),
        .locked    (locked),
        .phase     (phase),
        .err_cnt   (err_cnt),
        .sump      (sump)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_sof(input int ch, input logic [7:0] val);
        sof_word[ch*FB +: FB] = val;
    endtask

    function automatic logic [7:0] align_ref(input logic [7:0] cur, input logic [7:0] prev, input int k);
        logic [15:0] cat;
        cat = {cur, prev};
        return cat[k +: 8];
    endfunction

    // Drive lane 0 of a channel, queue the expected aligned word, compare after the edge.
    task automatic data_step(input string tag, input int ch, input logic [7:0] cur, input logic [7:0] exp);
        sb_t e;
        data_word[ch*LN*FB +: FB] = cur;
        e.tag = tag;
        e.ch  = ch;
        e.exp = exp;
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        chk(e.tag, 256'(sbits[e.ch*LN*FB +: FB]), 256'(e.exp));
    endtask

    initial begin
        logic [7:0]       cur;
        logic [7:0]       last0;
        logic [NV*EW-1:0] exp_err;

        reset_i   = 1'b1;
        sbit_mask = '0;
        realign_i = 1'b0;
        sof_word  = '0;
        data_word = '0;
        repeat (3) tick();
        chk("rst_locked", 256'(locked), '0);
        chk("rst_err", 256'(err_cnt), '0);
        chk("rst_phase", 256'(phase), '0);
        chk("rst_sbits_zero", 256'(sbits != '0), '0);

        // Lock latency on channel 0 with a constant SOF at k=3.
        reset_i = 1'b0;
        set_sof(0, 8'h08);
        repeat (4) tick();
        chk("lock_lat_4", 256'(locked[0]), 256'(0));
        tick();
        chk("lock_lat_5", 256'(locked[0]), 256'(1));
        chk("lock_phase0", 256'(phase[0 +: PW]), 256'(3));
        chk("others_unlocked", 256'(locked[NV-1:1]), '0);

        // Alignment through the {current, previous} window.
        data_step("align_a5", 0, 8'hA5, align_ref(8'hA5, 8'h00, 3));
        data_step("align_94", 0, 8'h3C, 8'h94);
        last0 = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            cur = 8'($urandom);
            data_step("align_rand", 0, cur, align_ref(cur, last0, 3));
            last0 = cur;
        end

        // Single bad SOF keeps lock and counts one error.
        set_sof(0, 8'h00);
        tick();
        chk("miss1_locked", 256'(locked[0]), 256'(1));
        chk("miss1_err", 256'(err_cnt[0 +: EW]), 256'(1));
        set_sof(0, 8'h08);
        tick();
        chk("miss1_hold", 256'(locked[0]), 256'(1));
        chk("miss1_err_hold", 256'(err_cnt[0 +: EW]), 256'(1));

        // Two consecutive bad SOFs drop lock on channel 1.
        set_sof(1, 8'h40);
        repeat (5) tick();
        chk("c1_locked", 256'(locked[1]), 256'(1));
        chk("c1_phase", 256'(phase[1*PW +: PW]), 256'(6));
        set_sof(1, 8'h00);
        tick();
        chk("miss2_first_locked", 256'(locked[1]), 256'(1));
        chk("miss2_first_err", 256'(err_cnt[1*EW +: EW]), 256'(1));
        tick();
        chk("miss2_unlocked", 256'(locked[1]), 256'(0));
        chk("miss2_err", 256'(err_cnt[1*EW +: EW]), 256'(2));
        data_step("unlocked_sbits", 1, 8'hFF, 8'h00);
        chk("c0_unaffected", 256'(locked[0]), 256'(1));

        // CHECK restarts when the phase changes mid-qualification.
        set_sof(2, 8'h08);
        repeat (2) tick();
        set_sof(2, 8'h10);
        tick();
        chk("restart_phase", 256'(phase[2*PW +: PW]), 256'(4));
        chk("restart_unlocked", 256'(locked[2]), 256'(0));
        repeat (3) tick();
        chk("restart_6th", 256'(locked[2]), 256'(0));
        tick();
        chk("restart_locked", 256'(locked[2]), 256'(1));
        chk("restart_phase_final", 256'(phase[2*PW +: PW]), 256'(4));

        // Lock every channel, then realign alongside good SOFs.
        set_sof(1, 8'h40);
        for (int c = 3; c < NV; c++) set_sof(c, 8'h01);
        repeat (5) tick();
        chk("all_locked", 256'(locked), 256'({NV{1'b1}}));
        exp_err = '0;
        exp_err[0*EW +: EW] = 8'd1;
        exp_err[1*EW +: EW] = 8'd2;
        realign_i = 1'b1;
        tick();
        realign_i = 1'b0;
        chk("realign_drop", 256'(locked), '0);
        chk("realign_err_kept", 256'(err_cnt), 256'(exp_err));
        repeat (4) tick();
        chk("relock_4", 256'(locked), '0);
        tick();
        chk("relock_5", 256'(locked), 256'({NV{1'b1}}));

        // Mask channel 5; hammer channel 6 with alternating bad/good SOFs.
        sbit_mask[5] = 1'b1;
        for (int i = 0; i < 255; i++) begin
            set_sof(5, 8'h00);
            set_sof(6, 8'h00);
            tick();
            set_sof(5, 8'h01);
            set_sof(6, 8'h01);
            tick();
        end
        chk("c6_err_ff", 256'(err_cnt[6*EW +: EW]), 256'(8'hFF));
        chk("c6_locked", 256'(locked[6]), 256'(1));
        chk("c5_unlocked", 256'(locked[5]), 256'(0));
        chk("c5_err_zero", 256'(err_cnt[5*EW +: EW]), '0);
        for (int i = 0; i < 5; i++) begin
            set_sof(6, 8'h00);
            tick();
            set_sof(6, 8'h01);
            tick();
        end
        chk("c6_err_sat", 256'(err_cnt[6*EW +: EW]), 256'(8'hFF));
        data_step("c5_masked_sbits", 5, 8'h5A, 8'h00);
        data_step("c6_live_sbits", 6, 8'hC3, align_ref(8'hC3, 8'h00, 0));
        chk("c5_still_unlocked", 256'(locked[5]), 256'(0));

        // Reset while locked, then recover.
        reset_i = 1'b1;
        tick();
        chk("midrst_locked", 256'(locked), '0);
        chk("midrst_err", 256'(err_cnt), '0);
        chk("midrst_sbits_zero", 256'(sbits != '0), '0);
        reset_i   = 1'b0;
        sbit_mask = '0;
        repeat (4) tick();
        chk("postrst_4", 256'(locked), '0);
        tick();
        chk("postrst_5", 256'(locked), 256'({NV{1'b1}}));
        chk("sb_drained", 256'(sb_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
